// File: rtl/bcd_to_bin_if.sv
// Handshake bundle for the sequential BCD-to-binary converter.
// The master side requests a conversion (start/bcd). The slave side returns
// the result (binario/valid), the in-progress flag (busy) and the
// invalid-digit flag (err).
interface bcd_to_bin_if #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd;
  logic [BIN_W-1:0]      binario;
  logic                  valid;
  logic                  busy;
  logic                  err;

  modport master (output start, bcd, input binario, valid, busy, err);
  modport slave  (input start, bcd, output binario, valid, busy, err);
endinterface

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter using reverse double-dabble.
// Each CONV cycle shifts {bcd_reg, bin_reg} right by one bit. It then
// subtracts 3 from every BCD digit that is >= 8. After BIN_W iterations,
// bin_reg holds the binary value.
// Optional macro BCD_DIGIT_CHECK_EN rejects operands with a digit > 9. A
// rejected operand produces binario=0 and err=1 one cycle after accept.
// Without the macro, err is tied low.
module bcd_to_bin #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic            clk,
  input  logic            rst,
  bcd_to_bin_if.slave     bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [BCD_W-1:0]   bcd_reg;
  logic [BIN_W-1:0]   bin_reg;
  logic [CNT_W-1:0]   cnt;
  logic [BIN_W-1:0]   binario_r;
  logic               valid_r;
  logic               busy_r;

  logic [BCD_W-1:0]   bcd_shift;
  logic [BCD_W-1:0]   bcd_fix;
  logic [BIN_W-1:0]   bin_shift;

  // One iteration: shift the pair right, then correct each digit on its own
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch
    bcd_shift = bcd_reg >> 1;
    bin_shift = {bcd_reg[0], bin_reg[BIN_W-1:1]};
    bcd_fix   = bcd_shift;
    for (int d = 0; d < DIGITS; d++) begin
      // digit >= 8 is exactly "top bit set"; 4-bit subtract, no cross-digit borrow
      if (bcd_shift[4*d+3])
        bcd_fix[4*d +: 4] = bcd_shift[4*d +: 4] - 4'd3;
    end
  end

`ifdef BCD_DIGIT_CHECK_EN
  logic err_r;
  logic bad_digit;

  // Flag any operand digit outside 0..9
  always_comb begin
    bad_digit = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (bus.bcd[4*d +: 4] > 4'd9)
        bad_digit = 1'b1;
    end
  end
`endif

  // Control FSM, datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the shift register is reset along with the control state so
      // an aborted conversion leaves no stale operand behind
      state     <= IDLE;
      bcd_reg   <= '0;
      bin_reg   <= '0;
      cnt       <= '0;
      binario_r <= '0;
      valid_r   <= 1'b0;
      busy_r    <= 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
      err_r     <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values
      case (state)
        IDLE: begin
          if (bus.start) begin
`ifdef BCD_DIGIT_CHECK_EN
            if (bad_digit) begin
              binario_r <= '0;
              err_r     <= 1'b1;
              valid_r   <= 1'b1;
              state     <= DONE;
            end else begin
              err_r   <= 1'b0;
              bcd_reg <= bus.bcd;
              bin_reg <= '0;
              cnt     <= '0;
              busy_r  <= 1'b1;
              state   <= CONV;
            end
`else
            bcd_reg <= bus.bcd;
            bin_reg <= '0;
            cnt     <= '0;
            busy_r  <= 1'b1;
            state   <= CONV;
`endif
          end
        end

        CONV: begin
          bcd_reg <= bcd_fix;
          bin_reg <= bin_shift;
          cnt     <= cnt + 1'b1;
          if (cnt == LAST_ITER) begin
            binario_r <= bin_shift;
            valid_r   <= 1'b1;
            busy_r    <= 1'b0;
            state     <= DONE;
          end
        end

        DONE: begin
          valid_r <= 1'b0;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.binario = binario_r;
  assign bus.valid   = valid_r;
  assign bus.busy    = busy_r;
`ifdef BCD_DIGIT_CHECK_EN
  assign bus.err     = err_r;
`else
  assign bus.err     = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin: vector table, hand-written corner
// sequences (ignored restarts, mid-conversion reset, invalid digit) and
// random valid operands against a decimal-arithmetic reference.
module tb_bcd_to_bin;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;

  logic clk;
  logic rst;

  bcd_to_bin_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

  bcd_to_bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] bcd;
    int          exp_bin;
  } vec_t;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Reference: decimal value of a packed BCD word
  function automatic int bcd_value(input logic [15:0] v);
    int acc = 0;
    int w   = 1;
    for (int d = 0; d < DIGITS; d++) begin
      acc += int'(v[4*d +: 4]) * w;
      w   *= 10;
    end
    return acc;
  endfunction

  // Issue one start, then wait (bounded) for valid.
  // lat = edges after the accept edge; busy_cnt = cycles observed busy.
  task automatic run_conv(input logic [15:0] v, output int lat, output int busy_cnt);
    lat      = -1;
    busy_cnt = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.bcd   = v;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    if (bus.busy) busy_cnt++;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.valid) begin
        lat = i;
        break;
      end
      if (bus.busy) busy_cnt++;
    end
    if (lat > 0) begin
      @(posedge clk);
      #1;
      check("valid_one_cycle", int'(bus.valid), 0);
    end
  endtask

  initial begin
    vec_t vecs[8];
    int lat;
    int bcnt;
    int vcount;
    int vlat;
    logic [15:0] r;

    vecs[0] = '{16'h0000, 0};
    vecs[1] = '{16'h9999, 9999};
    vecs[2] = '{16'h1234, 1234};
    vecs[3] = '{16'h0808, 808};
    vecs[4] = '{16'h0001, 1};
    vecs[5] = '{16'h5000, 5000};
    vecs[6] = '{16'h0099, 99};
    vecs[7] = '{16'h8080, 8080};

    bus.start = 1'b0;
    bus.bcd   = '0;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_binario", int'(bus.binario), 0);
    check("rst_valid",   int'(bus.valid),   0);
    check("rst_busy",    int'(bus.busy),    0);
    check("rst_err",     int'(bus.err),     0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      run_conv(vecs[i].bcd, lat, bcnt);
      check($sformatf("tbl%0d_latency", i), lat, BIN_W);
      check($sformatf("tbl%0d_busy_cycles", i), bcnt, BIN_W);
      check($sformatf("tbl%0d_binario", i), int'(bus.binario), vecs[i].exp_bin);
      check($sformatf("tbl%0d_err", i), int'(bus.err), 0);
    end

    // Starts while busy or in DONE are ignored; bcd change after accept has no effect
    @(negedge clk);
    bus.start = 1'b1;
    bus.bcd   = 16'h0042;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.bcd   = 16'h0777;
    vcount = 0;
    vlat   = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      bus.start = (c == 3 || c == 14 || c == 15);
      @(posedge clk);
      #1;
      if (bus.valid) begin
        vcount++;
        if (vlat < 0) vlat = c;
      end
    end
    bus.start = 1'b0;
    check("b2b_latency",     vlat, BIN_W);
    check("b2b_valid_count", vcount, 1);
    check("b2b_binario",     int'(bus.binario), 42);
    check("b2b_idle_busy",   int'(bus.busy), 0);
    run_conv(16'h0777, lat, bcnt);
    check("restart_latency", lat, BIN_W);
    check("restart_binario", int'(bus.binario), 777);

    // Reset in the middle of a conversion aborts it
    @(negedge clk);
    bus.start = 1'b1;
    bus.bcd   = 16'h5555;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("pre_abort_busy", int'(bus.busy), 1);
    rst = 1'b1;
    #1;
    check("abort_binario", int'(bus.binario), 0);
    check("abort_valid",   int'(bus.valid),   0);
    check("abort_busy",    int'(bus.busy),    0);
    check("abort_err",     int'(bus.err),     0);
    @(negedge clk);
    rst = 1'b0;
    vcount = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (bus.valid) vcount++;
    end
    check("abort_no_valid", vcount, 0);
    run_conv(16'h0001, lat, bcnt);
    check("post_abort_latency", lat, BIN_W);
    check("post_abort_binario", int'(bus.binario), 1);

    // Invalid digit handling
    run_conv(16'h12A4, lat, bcnt);
`ifdef BCD_DIGIT_CHECK_EN
    check("bad_latency", lat, 1);
    check("bad_binario", int'(bus.binario), 0);
    check("bad_err",     int'(bus.err), 1);
    repeat (3) @(posedge clk);
    #1;
    check("bad_err_hold", int'(bus.err), 1);
    run_conv(16'h0010, lat, bcnt);
    check("good_after_bad_latency", lat, BIN_W);
    check("good_after_bad_err",     int'(bus.err), 0);
    check("good_after_bad_binario", int'(bus.binario), 10);
`else
    check("bad_latency", lat, BIN_W);
    check("bad_err",     int'(bus.err), 0);
`endif

    // Random valid operands against the decimal reference
    for (int k = 0; k < 20; k++) begin
      for (int d = 0; d < DIGITS; d++)
        r[4*d +: 4] = 4'($urandom_range(0, 9));
      run_conv(r, lat, bcnt);
      check($sformatf("rnd%0d_latency", k), lat, BIN_W);
      check($sformatf("rnd%0d_binario_%h", k, r), int'(bus.binario), bcd_value(r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_to_bin.md
Name: bcd_to_bin

Overview:
Sequential BCD-to-binary converter. Uses reverse double-dabble: shift right one bit per clock, then subtract 3 from every BCD digit >= 8.
Inverse of the combinational binary-to-BCD block. Converts operands entered as decimal digits (keypad/display path) into binary before they reach the Booth multiplier.
Start/valid handshake. One conversion in flight.

Parameters:
DIGITS, 4, number of packed BCD input digits
BIN_W, 14, binary result width; must satisfy 2^BIN_W > 10^DIGITS - 1 (14 for 4 digits)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
start  input  1  request conversion; sampled only in IDLE
bcd  input  4*DIGITS  packed BCD operand; digit 0 = bcd[3:0]; sampled on the accepted start edge only
binario  output  BIN_W  binary result; registered
valid  output  1  one-cycle pulse: binario/err updated
busy  output  1  high while in CONV
err  output  1  invalid-digit flag (optional feature)

Behaviour:
- Reset (async, immediate): state=IDLE, binario=0, valid=0, busy=0, err=0, counter=0, shift register=0. Asserting rst mid-conversion aborts it; no valid pulse is produced for it.
- Internal shift register: {bcd_reg (4*DIGITS bits), bin_reg (BIN_W bits)}.
- Iteration counter: ceil(log2(BIN_W+1)) bits.
- State IDLE:
  - On edge N with start=1: load bcd_reg<=bcd, bin_reg<=0, counter<=0, busy<=1, go to CONV.
  - start=0: stay in IDLE.
- State CONV, one iteration per edge:
  - Shift the whole register right 1 bit; the LSB of bcd_reg enters the MSB of bin_reg.
  - Then, for each digit of the shifted bcd_reg: if digit >= 8, digit <= digit - 3. Digits are corrected independently in the same cycle. Subtraction is 4-bit; no borrow crosses digits.
  - Iterations occur at edges N+1 .. N+BIN_W.
  - At edge N+BIN_W: binario <= final bin_reg, valid<=1, busy<=0, go to DONE.
- State DONE: lasts one cycle. valid<=0, go to IDLE.
- Timing:
  - valid is high exactly one cycle, after edge N+BIN_W.
  - Minimum start-to-start spacing: BIN_W+2 cycles.
- start while busy=1 or in DONE: ignored. No queuing, no effect on the result in flight.
- bcd changes after the accept edge: no effect on the conversion in flight.
- binario holds the last result until the next valid pulse; it is not cleared by start.
- Result range: 0 .. 10^DIGITS-1. No overflow is possible given the BIN_W constraint.

Optional Feature:
Macro BCD_DIGIT_CHECK_EN.
- Defined:
  - At the accept edge, if any input digit > 9: skip CONV and go straight to DONE. binario<=0, err<=1, valid<=1 in the cycle after edge N (latency 1).
  - Valid input: err<=0 at the accept edge.
  - err holds its value until the next accepted start.
- Not defined:
  - err tied to 0.
  - Digits are not checked; invalid digits run the normal algorithm and the result is unspecified but deterministic.

Test Plan:
- Reset then start with bcd=16'h0000 -> valid after exactly 14 cycles, binario=0, err=0; busy high 14 cycles.
- bcd=16'h9999 -> binario=14'h270F (9999). bcd=16'h1234 -> binario=14'h04D2 (1234). bcd=16'h0808 -> 808 (14'h0328).
- Back-to-back: start 16'h0042, then pulse start with 16'h0777 at cycles 3 and 14 after accept -> both ignored, binario=42 only. Restart in IDLE gives 777.
- Assert rst at iteration 7 of a 16'h5555 conversion -> all outputs 0 immediately, no valid. Next start with 16'h0001 -> binario=1.
- With BCD_DIGIT_CHECK_EN: bcd=16'h12A4 -> valid one cycle after accept, binario=0, err=1. Following 16'h0010 -> err=0, binario=10.
- Without the macro: bcd=16'h12A4 -> err stays 0, valid after 14 cycles.
